// File: rtl/ovl_win_sched_pkg.sv
// Shared types and defaults for the
// round-robin window-check scheduler.
package ovl_win_sched_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_LENW  = 4;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    WIN,
    CLOSE
  } state_t;

endpackage

// File: rtl/ovl_win_sched_if.sv
// Requester and checker-side bundle of
// the window scheduler.
interface ovl_win_sched_if
  import ovl_win_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int LENW  = DEF_LENW
);
  localparam int IDW = $clog2(NREQ);

  logic                    enable;
  logic [NREQ-1:0]         req;
  logic [NREQ*LENW-1:0]    req_len;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         gnt;
  logic                    start_event;
  logic                    end_event;
  logic [WIDTH-1:0]        test_expr;
  logic                    busy;
  logic                    done;
  logic [IDW-1:0]          done_id;
  logic                    fail;

  modport master (
    output enable, req, req_len, req_data,
    input  gnt, start_event, end_event,
    input  test_expr, busy, done, done_id, fail
  );

  modport slave (
    input  enable, req, req_len, req_data,
    output gnt, start_event, end_event,
    output test_expr, busy, done, done_id, fail
  );

endinterface

// File: rtl/ovl_win_sched_rr_arb.sv
// Round-robin pick: search upward from
// last_id+1, wrapping.
module ovl_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_id,
  output logic            valid,
  output logic [IDW-1:0]  id
);

  int j;

  // Walk lowest priority first so the
  // nearest successor overwrites last.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    j     = 0;
    for (int i = NREQ; i >= 1; i--) begin
      j = int'(last_id) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[j[IDW-1:0]]) begin
        valid = 1'b1;
        id    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/ovl_win_sched.sv
// Grants one requester at a time a
// stability window for ovl_win_unchange.
module ovl_win_sched
  import ovl_win_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int LENW  = DEF_LENW
) (
  input logic            clock,
  input logic            reset,
  ovl_win_sched_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_t           state;
  logic [IDW-1:0]   id;
  logic [IDW-1:0]   last_id;
  logic [IDW-1:0]   pick_id;
  logic             pick_valid;
  logic [LENW-1:0]  len;
  logic [LENW-1:0]  cnt;
  logic [WIDTH-1:0] snap;
  logic [WIDTH-1:0] cur;
  logic             mismatch;
  logic             changed;

  ovl_rr_arb #(.NREQ(NREQ)) u_arb (
    .req     (bus.req),
    .last_id (last_id),
    .valid   (pick_valid),
    .id      (pick_id)
  );

  assign cur     = bus.req_data[int'(id)*WIDTH +: WIDTH];
  assign changed = (cur != snap);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      id       <= '0;
      last_id  <= IDW'(NREQ-1);
      len      <= '0;
      cnt      <= '0;
      snap     <= '0;
      mismatch <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.enable && pick_valid) begin
            id    <= pick_id;
            len   <= bus.req_len[int'(pick_id)*LENW +: LENW];
            state <= OPEN;
          end
        end
        OPEN: begin
          snap     <= cur;
          cnt      <= (len == '0) ? LENW'(1) : len;
          mismatch <= 1'b0;
          state    <= WIN;
        end
        WIN: begin
          mismatch <= mismatch | changed;
          cnt      <= cnt - LENW'(1);
          if (cnt == LENW'(1)) state <= CLOSE;
        end
        CLOSE: begin
          last_id <= id;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Everything below decodes registered
  // state; only test_expr/fail see data.
  always_comb begin
    bus.busy        = (state != IDLE);
    bus.gnt         = bus.busy ? (NREQ'(1) << id) : '0;
    bus.start_event = (state == OPEN);
    bus.end_event   = (state == CLOSE);
    bus.done        = (state == CLOSE);
    bus.done_id     = bus.done ? id : '0;
    bus.fail        = bus.done & (mismatch | changed);
    bus.test_expr   = bus.busy ? cur : '0;
  end

endmodule

// File: tb/tb_ovl_win_sched.sv
// Scenario bench for ovl_win_sched with a
// behavioural unchange checker.
module tb_ovl_win_sched;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ovl_win_sched_if #(.WIDTH(4), .NREQ(4), .LENW(4)) bus ();

  ovl_win_sched #(.WIDTH(4), .NREQ(4), .LENW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Downstream unchange checker model
  logic [3:0] chk_snap;
  logic       chk_act;
  logic       chk_bad;
  logic       fire;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      chk_act  <= 1'b0;
      chk_bad  <= 1'b0;
      chk_snap <= '0;
    end else if (bus.start_event) begin
      chk_act  <= 1'b1;
      chk_bad  <= 1'b0;
      chk_snap <= bus.test_expr;
    end else if (chk_act) begin
      if (bus.end_event) chk_act <= 1'b0;
      else chk_bad <= chk_bad | (bus.test_expr != chk_snap);
    end
  end

  assign fire = bus.end_event & chk_act &
                (chk_bad | (bus.test_expr != chk_snap));

  typedef struct {
    int id;
    bit fl;
    int span;
  } exp_t;

  exp_t sbq[$];

  task automatic wait_ev(input bit on_done, input int budget,
                         output bit hit, output int at);
    hit = 1'b0;
    at  = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      if (on_done ? bus.done : bus.start_event) begin
        hit = 1'b1;
        at  = cyc;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable   = 1'b1;
    bus.req      = 4'b1111;
    bus.req_len  = 16'h1111;
    bus.req_data = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_chk++;
      if ({bus.gnt, bus.start_event, bus.done, bus.busy,
           bus.test_expr} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold gnt=%b start=%b done=%b busy=%b exp=0",
                 bus.gnt, bus.start_event, bus.done, bus.busy);
      end
    end
    bus.req = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    bit   hit;
    int   t0, t1;
    exp_t e;
    bus.req_len[0 +: 4]  = 4'd2;
    bus.req_data[0 +: 4] = 4'hA;
    bus.enable = 1'b1;
    sbq.push_back('{0, 1'b0, 3});
    bus.req = 4'b0001;
    wait_ev(1'b0, 10, hit, t0);
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL basic_start timeout, required start_event");
    end
    n_chk++;
    if (bus.gnt !== 4'b0001 || bus.test_expr !== 4'hA) begin
      n_fail++;
      $display("FAIL basic_gnt gnt=%b expr=%h, required 0001/a",
               bus.gnt, bus.test_expr);
    end
    bus.req = '0;
    wait_ev(1'b1, 10, hit, t1);
    e = sbq.pop_front();
    n_chk++;
    if (!hit || t1 - t0 != e.span) begin
      n_fail++;
      $display("FAIL basic_span hit=%0b span=%0d, required %0d",
               hit, t1 - t0, e.span);
    end
    n_chk++;
    if ({bus.end_event, bus.done_id, bus.fail, fire} !==
        {1'b1, 2'(e.id), e.fl, e.fl}) begin
      n_fail++;
      $display("FAIL basic_done end=%b id=%0d fail=%b fire=%b, required 1/%0d/%b/%b",
               bus.end_event, bus.done_id, bus.fail, fire, e.id, e.fl, e.fl);
    end
  endtask

  task automatic test_fail();
    bit   hit;
    int   t0, t1;
    exp_t e;
    bus.req_len[4 +: 4]  = 4'd2;
    bus.req_data[4 +: 4] = 4'hA;
    sbq.push_back('{1, 1'b1, 3});
    bus.req = 4'b0010;
    wait_ev(1'b0, 10, hit, t0);
    n_chk++;
    if (!hit || bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL fail_start hit=%0b gnt=%b, required 1/0010", hit, bus.gnt);
    end
    bus.req = '0;
    @(negedge clock);
    bus.req_data[4 +: 4] = 4'h9;
    wait_ev(1'b1, 10, hit, t1);
    e = sbq.pop_front();
    n_chk++;
    if (!hit || t1 - t0 != e.span) begin
      n_fail++;
      $display("FAIL fail_span hit=%0b span=%0d, required %0d",
               hit, t1 - t0, e.span);
    end
    n_chk++;
    if ({bus.done_id, bus.fail, fire} !== {2'(e.id), e.fl, e.fl}) begin
      n_fail++;
      $display("FAIL fail_done id=%0d fail=%b fire=%b, required %0d/%b/%b",
               bus.done_id, bus.fail, fire, e.id, e.fl, e.fl);
    end
  endtask

  task automatic test_round_robin();
    bit         hit;
    int         t0, t1, prev;
    exp_t       e;
    logic [3:0] g;
    bus.req = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    bus.req_len  = 16'h1111;
    bus.req_data = 16'h4321;
    for (int k = 0; k < 5; k++) sbq.push_back('{k % 4, 1'b0, 2});
    bus.req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ev(1'b0, 8, hit, t0);
      if (k == 4) bus.req = '0;
      e = sbq.pop_front();
      g = 4'b0001 << e.id;
      n_chk++;
      if (!hit || bus.gnt !== g) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d] hit=%0b gnt=%b, required %b",
                 k, hit, bus.gnt, g);
      end
      if (k > 0) begin
        n_chk++;
        if (t0 - prev != 4) begin
          n_fail++;
          $display("FAIL rr_spacing[%0d] got %0d, required 4", k, t0 - prev);
        end
      end
      prev = t0;
      wait_ev(1'b1, 6, hit, t1);
      n_chk++;
      if (!hit || t1 - t0 != e.span || bus.done_id !== 2'(e.id)) begin
        n_fail++;
        $display("FAIL rr_done[%0d] span=%0d id=%0d, required %0d/%0d",
                 k, t1 - t0, bus.done_id, e.span, e.id);
      end
    end
  endtask

  task automatic test_len0();
    bit   hit;
    int   t0, t1;
    exp_t e;
    bus.req_len[8 +: 4]  = 4'd0;
    bus.req_data[8 +: 4] = 4'h5;
    sbq.push_back('{2, 1'b0, 2});
    bus.req = 4'b0100;
    wait_ev(1'b0, 10, hit, t0);
    bus.req = '0;
    wait_ev(1'b1, 10, hit, t1);
    e = sbq.pop_front();
    n_chk++;
    if (!hit || t1 - t0 != e.span) begin
      n_fail++;
      $display("FAIL len0_span hit=%0b span=%0d, required %0d",
               hit, t1 - t0, e.span);
    end
    n_chk++;
    if ({bus.done_id, bus.fail, fire} !== {2'(e.id), e.fl, e.fl}) begin
      n_fail++;
      $display("FAIL len0_done id=%0d fail=%b fire=%b, required %0d/0/0",
               bus.done_id, bus.fail, fire, e.id);
    end
  endtask

  task automatic test_enable();
    bit   hit;
    int   t0, t1;
    exp_t e;
    bus.req_len[12 +: 4]  = 4'd3;
    bus.req_data[12 +: 4] = 4'h7;
    sbq.push_back('{3, 1'b0, 4});
    bus.req = 4'b1000;
    wait_ev(1'b0, 10, hit, t0);
    @(negedge clock);
    bus.enable = 1'b0;
    bus.req_len[12 +: 4] = 4'd0;
    wait_ev(1'b1, 10, hit, t1);
    e = sbq.pop_front();
    n_chk++;
    if (!hit || t1 - t0 != e.span || bus.done_id !== 2'(e.id)) begin
      n_fail++;
      $display("FAIL en_span hit=%0b span=%0d id=%0d, required %0d/%0d",
               hit, t1 - t0, bus.done_id, e.span, e.id);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_chk++;
      if (bus.busy !== 1'b0 || bus.start_event !== 1'b0) begin
        n_fail++;
        $display("FAIL en_hold[%0d] busy=%b start=%b, required 0/0",
                 i, bus.busy, bus.start_event);
      end
    end
    sbq.push_back('{3, 1'b0, 2});
    bus.enable = 1'b1;
    wait_ev(1'b0, 4, hit, t0);
    bus.req = '0;
    n_chk++;
    if (!hit || bus.gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL en_resume hit=%0b gnt=%b, required 1/1000", hit, bus.gnt);
    end
    wait_ev(1'b1, 8, hit, t1);
    e = sbq.pop_front();
    n_chk++;
    if (!hit || t1 - t0 != e.span) begin
      n_fail++;
      $display("FAIL en_resume_span span=%0d, required %0d", t1 - t0, e.span);
    end
  endtask

  task automatic test_abort();
    bit hit;
    int t0;
    bus.req_len[0 +: 4]  = 4'd5;
    bus.req_data[0 +: 4] = 4'h3;
    bus.req = 4'b0001;
    wait_ev(1'b0, 10, hit, t0);
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_start timeout, required start_event");
    end
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({bus.gnt, bus.start_event, bus.end_event, bus.done, bus.busy,
         bus.test_expr, bus.fail, bus.done_id} !== '0) begin
      n_fail++;
      $display("FAIL abort_async gnt=%b busy=%b expr=%h, required all 0",
               bus.gnt, bus.busy, bus.test_expr);
    end
    bus.req = '0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_chk++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet[%0d] done=%b busy=%b, required 0/0",
                 i, bus.done, bus.busy);
      end
    end
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.req      = '0;
    bus.req_len  = '0;
    bus.req_data = '0;
    test_reset();
    test_basic();
    test_fail();
    test_round_robin();
    test_len0();
    test_enable();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
